// File: rtl/usb_crc_append.sv
// Serial CRC generator for the USB transmit bit path: zero-latency pass-through, complemented remainder appended MSB-first.
// Optional receive-side residue check is compiled in when USB_CRC_CHECK_EN is defined (adds check / crc_err ports).
module usb_crc_append #(
    parameter int              MAXW  = 16,
    parameter int              W0    = 5,
    parameter logic [MAXW-1:0] POLY0 = 16'h0005,
    parameter int              W1    = 16,
    parameter logic [MAXW-1:0] POLY1 = 16'h8005
`ifdef USB_CRC_CHECK_EN
    ,
    parameter logic [MAXW-1:0] RES0  = 16'h000C,
    parameter logic [MAXW-1:0] RES1  = 16'h800D
`endif
) (
    input  logic clk,
    input  logic rst_L,
    input  logic in_bit,
    input  logic in_valid,
    input  logic skip,
    input  logic sel,
    input  logic pause_out,
`ifdef USB_CRC_CHECK_EN
    input  logic check,
    output logic crc_err,
`endif
    output logic pause_in,
    output logic out_bit,
    output logic out_valid,
    output logic busy
);

    localparam int IW = $clog2(MAXW + 1);
    localparam logic [MAXW-1:0] MASK0 = MAXW'((64'd1 << W0) - 64'd1);
    localparam logic [MAXW-1:0] MASK1 = MAXW'((64'd1 << W1) - 64'd1);
    localparam logic [IW-1:0]   LAST0 = IW'(W0 - 1);
    localparam logic [IW-1:0]   LAST1 = IW'(W1 - 1);

    typedef enum logic [1:0] {IDLE, CALC, APPEND} state_t;

    state_t          state_reg, state_next;
    logic [MAXW-1:0] crc_reg, crc_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic            mode_reg, mode_next;
    logic            chk_mode;

    logic            mode_eff;
    logic            advance;
    logic            fb;
    logic            crc_msb;
    logic            crc_app;
    logic [MAXW-1:0] poly;
    logic [MAXW-1:0] mask;
    logic [IW-1:0]   last;
    logic [MAXW-1:0] crc_shift;

`ifdef USB_CRC_CHECK_EN
    logic            check_reg, check_next;
    logic            res_ok;
    assign chk_mode = check_reg;
    assign res_ok   = (crc_reg & mask) == ((mode_reg ? RES1 : RES0) & mask);
`else
    assign chk_mode = 1'b0;
`endif

    // In IDLE the packet's first bit is shifted with the mode it is about to latch.
    assign mode_eff  = (state_reg == IDLE) ? sel : mode_reg;
    assign poly      = mode_eff ? POLY1 : POLY0;
    assign mask      = mode_eff ? MASK1 : MASK0;
    assign last      = mode_eff ? LAST1 : LAST0;
    assign advance   = ~pause_out;

    assign crc_msb   = |((crc_reg >> last) & MAXW'(1));
    assign crc_app   = |((crc_reg >> (last - idx_reg)) & MAXW'(1));
    assign fb        = in_bit ^ crc_msb;
    assign crc_shift = ((crc_reg << 1) ^ (fb ? poly : '0)) & mask;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_reg <= IDLE;
            crc_reg   <= '1;
            idx_reg   <= '0;
            mode_reg  <= 1'b0;
`ifdef USB_CRC_CHECK_EN
            check_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            crc_reg   <= crc_next;
            idx_reg   <= idx_next;
            mode_reg  <= mode_next;
`ifdef USB_CRC_CHECK_EN
            check_reg <= check_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        crc_next   = crc_reg;
        idx_next   = idx_reg;
        mode_next  = mode_reg;
`ifdef USB_CRC_CHECK_EN
        check_next = check_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid && advance) begin
                    mode_next = sel;
`ifdef USB_CRC_CHECK_EN
                    check_next = check;
`endif
                    if (!skip) crc_next = crc_shift;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (advance) begin
                    if (in_valid) begin
                        if (!skip) crc_next = crc_shift;
                    end else if (chk_mode || last == '0) begin
                        crc_next   = '1;
                        state_next = IDLE;
                    end else begin
                        idx_next   = IW'(1);
                        state_next = APPEND;
                    end
                end
            end
            APPEND: begin
                if (advance) begin
                    if (idx_reg == last) begin
                        crc_next   = '1;
                        idx_next   = '0;
                        state_next = IDLE;
                    end else begin
                        idx_next = idx_reg + IW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                crc_next   = '1;
                idx_next   = '0;
            end
        endcase
    end

    always_comb begin
        out_bit   = in_bit;
        out_valid = in_valid;
        pause_in  = pause_out;
        busy      = (state_reg != IDLE);
`ifdef USB_CRC_CHECK_EN
        crc_err   = 1'b0;
`endif
        case (state_reg)
            CALC: begin
                // First payload-free cycle: the MSB of the remainder goes out before any state moves.
                if (!in_valid && !chk_mode) begin
                    out_bit   = ~crc_msb;
                    out_valid = 1'b1;
                    pause_in  = 1'b1;
                end
`ifdef USB_CRC_CHECK_EN
                if (!in_valid && chk_mode) crc_err = ~res_ok;
`endif
            end
            APPEND: begin
                out_bit   = ~crc_app;
                out_valid = 1'b1;
                pause_in  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usb_crc_append.sv
// Directed bench for usb_crc_append: pass-through, CRC5/CRC16 append, stall, back-to-back, reset and optional residue check.
module tb_usb_crc_append;

    logic clk = 1'b0;
    logic rst_L, in_bit, in_valid, skip, sel, pause_out;
    logic pause_in, out_bit, out_valid, busy;
`ifdef USB_CRC_CHECK_EN
    logic check, crc_err;
`endif
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    usb_crc_append dut (
        .clk       (clk),
        .rst_L     (rst_L),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .skip      (skip),
        .sel       (sel),
        .pause_out (pause_out),
`ifdef USB_CRC_CHECK_EN
        .check     (check),
        .crc_err   (crc_err),
`endif
        .pause_in  (pause_in),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // bits[i]/skips[i] are the i-th payload bit; sel is flipped after the first bit to prove it is latched.
    task automatic payload(input int n, input logic [31:0] bits, input logic [31:0] skips, input logic m);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_bit   = bits[i];
            skip     = skips[i];
            sel      = (i == 0) ? m : ~m;
            #1;
            chk("pass_bit", {31'd0, out_bit}, {31'd0, bits[i]});
            chk("pass_valid", {31'd0, out_valid}, 32'd1);
            chk("pass_pause", {31'd0, pause_in}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        skip     = 1'b0;
    endtask

    task automatic append(input int w, input logic [15:0] exp_val, input int stall_at,
                          input int stall_len, input int rst_at);
        for (int i = 0; i < w; i++) begin
            #1;
            if (i == rst_at) begin
                rst_L = 1'b0;
                #1;
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_pause", {31'd0, pause_in}, 32'd0);
                chk("rst_valid", {31'd0, out_valid}, 32'd0);
                #2;
                rst_L = 1'b1;
                tick();
                return;
            end
            chk("app_bit", {31'd0, out_bit}, {31'd0, exp_val[w-1-i]});
            chk("app_valid", {31'd0, out_valid}, 32'd1);
            chk("app_pause", {31'd0, pause_in}, 32'd1);
            chk("app_busy", {31'd0, busy}, 32'd1);
            if (i == stall_at) begin
                pause_out = 1'b1;
                for (int k = 0; k < stall_len; k++) begin
                    tick();
                    #1;
                    chk("stall_bit", {31'd0, out_bit}, {31'd0, exp_val[w-1-i]});
                    chk("stall_pause", {31'd0, pause_in}, 32'd1);
                    chk("stall_busy", {31'd0, busy}, 32'd1);
                end
                pause_out = 1'b0;
            end
            tick();
        end
        #1;
        chk("end_busy", {31'd0, busy}, 32'd0);
        chk("end_pause", {31'd0, pause_in}, 32'd0);
        chk("end_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_L     = 1'b0;
        in_valid  = 1'b1;
        in_bit    = 1'b1;
        skip      = 1'b0;
        sel       = 1'b0;
        pause_out = 1'b1;
`ifdef USB_CRC_CHECK_EN
        check     = 1'b0;
`endif
        #2;
        chk("reset_pause_in", {31'd0, pause_in}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd1);
        chk("reset_out_bit", {31'd0, out_bit}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
`ifdef USB_CRC_CHECK_EN
        chk("reset_crc_err", {31'd0, crc_err}, 32'd0);
`endif
        pause_out = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        #1;
        chk("reset_pause_low", {31'd0, pause_in}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_L = 1'b1;
        tick();

        // Mode-0 token of 11 zeros: remainder 10111, appended complement 01000.
        payload(11, 32'h0, 32'h0, 1'b0);
        append(5, 16'h0008, -1, 0, -1);

        // Mode-1 with only skipped PID bits: appends ~FFFF.
        payload(8, 32'hA5, 32'hFF, 1'b1);
        append(16, 16'h0000, -1, 0, -1);

        // Stall three cycles on the third appended bit.
        payload(11, 32'h0, 32'h0, 1'b0);
        append(5, 16'h0008, 2, 3, -1);

        // Back-to-back: token then mode-1 bits 1,0 -> crc 7FF9, appended 8006.
        payload(11, 32'h0, 32'h0, 1'b0);
        append(5, 16'h0008, -1, 0, -1);
        payload(2, 32'h1, 32'h0, 1'b1);
        append(16, 16'h8006, -1, 0, -1);

        // Reset during the fourth appended bit, then a clean token.
        payload(11, 32'h0, 32'h0, 1'b0);
        append(5, 16'h0008, -1, 0, 3);
        payload(11, 32'h0, 32'h0, 1'b0);
        append(5, 16'h0008, -1, 0, -1);

`ifdef USB_CRC_CHECK_EN
        check = 1'b1;
        payload(16, 32'h1000, 32'h0, 1'b0);
        #1;
        chk("chk_ok_err", {31'd0, crc_err}, 32'd0);
        chk("chk_ok_pause", {31'd0, pause_in}, 32'd0);
        tick();
        #1;
        chk("chk_ok_busy", {31'd0, busy}, 32'd0);
        payload(16, 32'h9000, 32'h0, 1'b0);
        #1;
        chk("chk_bad_err", {31'd0, crc_err}, 32'd1);
        chk("chk_bad_pause", {31'd0, pause_in}, 32'd0);
        tick();
        #1;
        chk("chk_bad_err_gone", {31'd0, crc_err}, 32'd0);
        chk("chk_bad_busy", {31'd0, busy}, 32'd0);
        check = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
